// File: rtl/id_ex_operand_stage.sv
`timescale 1ns/1ps
// id_ex_operand_stage
// Decode-to-execute boundary of the 5-stage pipeline. Resolves RAW hazards on
// both source operands by forwarding from EX/MEM/WB, detects load-use hazards
// (raising Stall), holds the ID/EX pipeline register with bubble insertion on
// stall/flush/invalid, and keeps a saturating stall-cycle counter.
//
// Ports
//   Clk, Clrn                      clock, async active-low reset
//   DValid, Rs, Rt, UseRs, UseRt   ID-stage instruction and its source usage
//   Qa, Qb                         register file read data for Rs/Rt
//   DImm, DWn, DWreg, DM2reg,
//   DWmem, DCtl                    decoded immediate, destination and control
//   E_Wn, E_Wreg, E_M2reg, E_Alu   EX-stage producer
//   M_Wn, M_Wreg, M_D              MEM-stage producer
//   W_Wn, W_We, W_D                WB-stage register file write port
//   Flush                          redirect: kill the instruction in ID
//   Stall                          combinational: freeze PC and IF/ID
//   EValid, EA, EB, EImm, EWn,
//   EWreg, EM2reg, EWmem, ECtl     registered ID/EX outputs
//   StallCnt                       saturating count of stall cycles
module id_ex_operand_stage #(
  parameter int unsigned CW = 8
) (
  input  logic            Clk,
  input  logic            Clrn,
  input  logic            DValid,
  input  logic [4:0]      Rs,
  input  logic [4:0]      Rt,
  input  logic            UseRs,
  input  logic            UseRt,
  input  logic [31:0]     Qa,
  input  logic [31:0]     Qb,
  input  logic [31:0]     DImm,
  input  logic [4:0]      DWn,
  input  logic            DWreg,
  input  logic            DM2reg,
  input  logic            DWmem,
  input  logic [CW-1:0]   DCtl,
  input  logic [4:0]      E_Wn,
  input  logic            E_Wreg,
  input  logic            E_M2reg,
  input  logic [31:0]     E_Alu,
  input  logic [4:0]      M_Wn,
  input  logic            M_Wreg,
  input  logic [31:0]     M_D,
  input  logic [4:0]      W_Wn,
  input  logic            W_We,
  input  logic [31:0]     W_D,
  input  logic            Flush,
  output logic            Stall,
  output logic            EValid,
  output logic [31:0]     EA,
  output logic [31:0]     EB,
  output logic [31:0]     EImm,
  output logic [4:0]      EWn,
  output logic            EWreg,
  output logic            EM2reg,
  output logic            EWmem,
  output logic [CW-1:0]   ECtl,
  output logic [15:0]     StallCnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CNTW = 16;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic            e_alu_fwd;
  logic            hz;
  logic            bubble;

  // An EX-stage load has no data yet; only ALU results forward from EX.
  assign e_alu_fwd = E_Wreg && !E_M2reg;

  // Operand A forward mux: r0 is hard zero, then youngest producer wins.
  always_comb begin
    fwd_a = Qa;
    if (Rs == RW'(0)) begin
      fwd_a = '0;
    end else if (e_alu_fwd && (E_Wn == Rs)) begin
      fwd_a = E_Alu;
    end else if (M_Wreg && (M_Wn == Rs)) begin
      fwd_a = M_D;
    end else if (W_We && (W_Wn == Rs)) begin
      // Register file writes on the same edge, so its read is still stale.
      fwd_a = W_D;
    end
  end

  // Operand B forward mux, same priority as A.
  always_comb begin
    fwd_b = Qb;
    if (Rt == RW'(0)) begin
      fwd_b = '0;
    end else if (e_alu_fwd && (E_Wn == Rt)) begin
      fwd_b = E_Alu;
    end else if (M_Wreg && (M_Wn == Rt)) begin
      fwd_b = M_D;
    end else if (W_We && (W_Wn == Rt)) begin
      fwd_b = W_D;
    end
  end

  // Load-use hazard: a load in EX targets a register this instruction reads.
  always_comb begin
    hz = 1'b0;
    if (DValid && E_Wreg && E_M2reg && (E_Wn != RW'(0))) begin
      hz = (UseRs && (E_Wn == Rs)) || (UseRt && (E_Wn == Rt));
    end
  end

  // A flush kills the dependent instruction, so there is nothing to hold.
  assign Stall  = hz && !Flush;
  assign bubble = Flush || hz || !DValid;

  // ID/EX pipeline register with bubble insertion.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      EValid <= 1'b0;
      EA     <= '0;
      EB     <= '0;
      EImm   <= '0;
      EWn    <= '0;
      EWreg  <= 1'b0;
      EM2reg <= 1'b0;
      EWmem  <= 1'b0;
      ECtl   <= '0;
    end else if (bubble) begin
      EValid <= 1'b0;
      EA     <= '0;
      EB     <= '0;
      EImm   <= '0;
      EWn    <= '0;
      EWreg  <= 1'b0;
      EM2reg <= 1'b0;
      EWmem  <= 1'b0;
      ECtl   <= '0;
    end else begin
      EValid <= 1'b1;
      EA     <= fwd_a;
      EB     <= fwd_b;
      EImm   <= DImm;
      EWn    <= DWn;
      EWreg  <= DWreg;
      EM2reg <= DM2reg;
      EWmem  <= DWmem;
      ECtl   <= DCtl;
    end
  end

  // Saturating stall-cycle counter for performance debug.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      StallCnt <= '0;
    end else if (Stall && (StallCnt != CNT_MAX)) begin
      StallCnt <= StallCnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for id_ex_operand_stage: expected ID/EX contents are pushed
// when stimulus is applied and popped/compared one edge later.
module tb_id_ex_operand_stage;

  logic        Clk, Clrn, DValid, UseRs, UseRt;
  logic [4:0]  Rs, Rt, DWn, E_Wn, M_Wn, W_Wn;
  logic [31:0] Qa, Qb, DImm, E_Alu, M_D, W_D;
  logic        DWreg, DM2reg, DWmem, E_Wreg, E_M2reg, M_Wreg, W_We, Flush;
  logic [7:0]  DCtl;
  logic        Stall, EValid, EWreg, EM2reg, EWmem;
  logic [31:0] EA, EB, EImm;
  logic [4:0]  EWn;
  logic [7:0]  ECtl;
  logic [15:0] StallCnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  wn;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [7:0]  ctl;
  } exp_t;

  exp_t sb[$];

  id_ex_operand_stage #(.CW(8)) dut (
    .Clk(Clk), .Clrn(Clrn), .DValid(DValid), .Rs(Rs), .Rt(Rt),
    .UseRs(UseRs), .UseRt(UseRt), .Qa(Qa), .Qb(Qb), .DImm(DImm),
    .DWn(DWn), .DWreg(DWreg), .DM2reg(DM2reg), .DWmem(DWmem), .DCtl(DCtl),
    .E_Wn(E_Wn), .E_Wreg(E_Wreg), .E_M2reg(E_M2reg), .E_Alu(E_Alu),
    .M_Wn(M_Wn), .M_Wreg(M_Wreg), .M_D(M_D),
    .W_Wn(W_Wn), .W_We(W_We), .W_D(W_D), .Flush(Flush),
    .Stall(Stall), .EValid(EValid), .EA(EA), .EB(EB), .EImm(EImm),
    .EWn(EWn), .EWreg(EWreg), .EM2reg(EM2reg), .EWmem(EWmem), .ECtl(ECtl),
    .StallCnt(StallCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference forward: apply producers oldest-first so younger ones overwrite.
  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] q);
    logic [31:0] v;
    v = q;
    if (W_We && W_Wn == r) v = W_D;
    if (M_Wreg && M_Wn == r) v = M_D;
    if (E_Wreg && !E_M2reg && E_Wn == r) v = E_Alu;
    if (r == 5'd0) v = 32'd0;
    return v;
  endfunction

  function automatic logic ref_hz();
    logic load_in_ex;
    load_in_ex = E_Wreg && E_M2reg && (E_Wn != 5'd0);
    return DValid && load_in_ex &&
           ((UseRs && E_Wn == Rs) || (UseRt && E_Wn == Rt));
  endfunction

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_evalid"}, 32'(EValid), 32'd0);
    check({pfx, "_ea"}, EA, 32'd0);
    check({pfx, "_eb"}, EB, 32'd0);
    check({pfx, "_eimm"}, EImm, 32'd0);
    check({pfx, "_ewn"}, 32'(EWn), 32'd0);
    check({pfx, "_eflags"}, 32'({EWreg, EM2reg, EWmem}), 32'd0);
    check({pfx, "_ectl"}, 32'(ECtl), 32'd0);
    check({pfx, "_stallcnt"}, 32'(StallCnt), 32'd0);
  endtask

  // Apply current inputs for one cycle: check Stall, push expectation,
  // clock, then pop and compare the registered outputs.
  task automatic step(input string tag);
    exp_t e;
    logic hz, st;
    #1;
    hz = ref_hz();
    st = hz && !Flush;
    check({tag, "_stall"}, 32'(Stall), 32'(st));
    e = '0;
    if (!(Flush || hz || !DValid)) begin
      e.v = 1'b1; e.a = ref_fwd(Rs, Qa); e.b = ref_fwd(Rt, Qb); e.imm = DImm;
      e.wn = DWn; e.wreg = DWreg; e.m2reg = DM2reg; e.wmem = DWmem; e.ctl = DCtl;
    end
    sb.push_back(e);
    if (st && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_evalid"}, 32'(EValid), 32'(e.v));
      check({tag, "_ea"}, EA, e.a);
      check({tag, "_eb"}, EB, e.b);
      check({tag, "_eimm"}, EImm, e.imm);
      check({tag, "_ewn"}, 32'(EWn), 32'(e.wn));
      check({tag, "_eflags"}, 32'({EWreg, EM2reg, EWmem}), 32'({e.wreg, e.m2reg, e.wmem}));
      check({tag, "_ectl"}, 32'(ECtl), 32'(e.ctl));
    end
    check({tag, "_stallcnt"}, 32'(StallCnt), 32'(exp_cnt));
  endtask

  task automatic idle_inputs();
    DValid = 1'b0; Rs = '0; Rt = '0; UseRs = 1'b0; UseRt = 1'b0;
    Qa = '0; Qb = '0; DImm = '0; DWn = '0; DWreg = 1'b0; DM2reg = 1'b0;
    DWmem = 1'b0; DCtl = '0; E_Wn = '0; E_Wreg = 1'b0; E_M2reg = 1'b0;
    E_Alu = '0; M_Wn = '0; M_Wreg = 1'b0; M_D = '0; W_Wn = '0; W_We = 1'b0;
    W_D = '0; Flush = 1'b0;
  endtask

  task automatic valid_instr();
    DValid = 1'b1; UseRs = 1'b1; UseRt = 1'b1;
    DImm = 32'hFFFF_FF80; DWn = 5'd9; DWreg = 1'b1; DM2reg = 1'b0;
    DWmem = 1'b0; DCtl = 8'h5A;
  endtask

  initial begin
    idle_inputs();
    Clrn = 1'b0;
    #2;
    check_outputs_zero("rst");
    #6 Clrn = 1'b1;
    @(posedge Clk);
    #1;

    // EX forward of an ALU result
    valid_instr();
    Rs = 5'd3; Rt = 5'd4; Qa = 32'h5; Qb = 32'h44;
    E_Wreg = 1'b1; E_Wn = 5'd3; E_Alu = 32'h0000_1234;
    step("exfwd");
    check("exfwd_ea_const", EA, 32'h0000_1234);

    // Priority on Rt: E over M over W over register file
    idle_inputs(); valid_instr();
    Rs = 5'd1; Qa = 32'h11; Rt = 5'd7; Qb = 32'h77;
    E_Wreg = 1'b1; E_Wn = 5'd7; E_Alu = 32'hA;
    M_Wreg = 1'b1; M_Wn = 5'd7; M_D = 32'hB;
    W_We = 1'b1; W_Wn = 5'd7; W_D = 32'hC;
    step("pri_e");
    check("pri_e_const", EB, 32'hA);
    E_Wreg = 1'b0;
    step("pri_m");
    check("pri_m_const", EB, 32'hB);
    M_Wreg = 1'b0;
    step("pri_w");
    check("pri_w_const", EB, 32'hC);
    W_We = 1'b0;
    step("pri_q");
    check("pri_q_const", EB, 32'h77);

    // Load-use: one stall cycle, then MEM forward of the load data
    idle_inputs(); valid_instr();
    Rs = 5'd2; Qa = 32'h22; Rt = 5'd5; Qb = 32'h55;
    E_Wreg = 1'b1; E_M2reg = 1'b1; E_Wn = 5'd5;
    step("lu_stall");
    check("lu_cnt_const", 32'(StallCnt), 32'd1);
    E_Wreg = 1'b0; E_M2reg = 1'b0;
    M_Wreg = 1'b1; M_Wn = 5'd5; M_D = 32'hDEAD_BEEF;
    step("lu_fwd");
    check("lu_fwd_const", EB, 32'hDEAD_BEEF);

    // Asynchronous reset mid-cycle, with a hazard pending on the inputs
    E_Wreg = 1'b1; E_M2reg = 1'b1; E_Wn = 5'd5; M_Wreg = 1'b0;
    #2 Clrn = 1'b0;
    #1;
    check_outputs_zero("arst");
    check("arst_stall_comb", 32'(Stall), 32'd1);
    #1 Clrn = 1'b1;
    exp_cnt = '0;
    step("arst_after");

    // r0 never forwarded and never a load-use hazard
    idle_inputs(); valid_instr();
    Rs = 5'd0; Rt = 5'd0; Qa = 32'h99; Qb = 32'h98;
    E_Wreg = 1'b1; E_M2reg = 1'b1; E_Wn = 5'd0;
    M_Wreg = 1'b1; M_Wn = 5'd0; M_D = 32'h1;
    step("r0");
    check("r0_ea_const", EA, 32'd0);

    // UseRs=0 masks the hazard on Rs only
    idle_inputs(); valid_instr();
    UseRs = 1'b0; Rs = 5'd9; Rt = 5'd10; Qa = 32'h909; Qb = 32'hA0A;
    E_Wreg = 1'b1; E_M2reg = 1'b1; E_Wn = 5'd9;
    step("users0");
    Rt = 5'd9;
    step("users0_rt");

    // Flush together with a load-use match
    idle_inputs(); valid_instr();
    Rs = 5'd6; Rt = 5'd8; E_Wreg = 1'b1; E_M2reg = 1'b1; E_Wn = 5'd6;
    Flush = 1'b1;
    step("flush_hz");

    // Constrained-random mix; small register range forces collisions
    for (int i = 0; i < 300; i++) begin
      DValid = ($urandom_range(0, 7) != 0);
      Rs = 5'($urandom_range(0, 3)); Rt = 5'($urandom_range(0, 3));
      UseRs = 1'($urandom_range(0, 1)); UseRt = 1'($urandom_range(0, 1));
      Qa = $urandom; Qb = $urandom; DImm = $urandom;
      DWn = 5'($urandom_range(0, 31)); DWreg = 1'($urandom_range(0, 1));
      DM2reg = 1'($urandom_range(0, 1)); DWmem = 1'($urandom_range(0, 1));
      DCtl = 8'($urandom_range(0, 255));
      E_Wn = 5'($urandom_range(0, 3)); E_Wreg = 1'($urandom_range(0, 1));
      E_M2reg = 1'($urandom_range(0, 1)); E_Alu = $urandom;
      M_Wn = 5'($urandom_range(0, 3)); M_Wreg = 1'($urandom_range(0, 1)); M_D = $urandom;
      W_Wn = 5'($urandom_range(0, 3)); W_We = 1'($urandom_range(0, 1)); W_D = $urandom;
      Flush = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    // Saturation: hold a load-use hazard for 70000 cycles
    idle_inputs(); valid_instr();
    Rs = 5'd4; E_Wreg = 1'b1; E_M2reg = 1'b1; E_Wn = 5'd4;
    #1;
    check("sat_stall", 32'(Stall), 32'd1);
    repeat (70000) @(posedge Clk);
    #1;
    check("sat_cnt", 32'(StallCnt), 32'h0000_FFFF);
    check("sat_bubble", 32'(EValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Decode-to-execute boundary stage of the 5-stage pipelined CPU, directly downstream of the register file's read ports. It takes raw register file read data plus decoded control, resolves RAW hazards by forwarding from the EX, MEM and WB stages, and detects load-use hazards, raising a stall. It holds the ID/EX pipeline register, inserting bubbles on stall or flush, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- `CW`, 8: width of the opaque decoded control bundle passed through to EX.
- `Clk` in 1: clock, all state updates on posedge.
- `Clrn` in 1: asynchronous active-low reset.
- `DValid` in 1: ID stage holds a real instruction.
- `Rs`, `Rt` in 5: source register numbers; also drive the register file `Ra`/`Rb`.
- `UseRs`, `UseRt` in 1: instruction actually reads `Rs`/`Rt`.
- `Qa`, `Qb` in 32: register file read data for `Rs`/`Rt`.
- `DImm` in 32: sign/zero-extended immediate.
- `DWn` in 5: destination register; `DWreg`, `DM2reg`, `DWmem` in 1: write-reg, load, store flags.
- `DCtl` in CW: remaining control, passed through unchanged.
- `E_Wn` in 5, `E_Wreg` in 1, `E_M2reg` in 1, `E_Alu` in 32: EX-stage destination, flags, ALU result.
- `M_Wn` in 5, `M_Wreg` in 1, `M_D` in 32: MEM-stage destination, write flag, final write data (ALU or load data).
- `W_Wn` in 5, `W_We` in 1, `W_D` in 32: WB-stage write port, same signals that drive the register file `Wn`/`We`/`D`.
- `Flush` in 1: branch/jump redirect; kill the instruction in ID.
- `Stall` out 1: freeze PC and IF/ID register this cycle.
- `EValid` out 1, `EA`, `EB`, `EImm` out 32, `EWn` out 5, `EWreg`, `EM2reg`, `EWmem` out 1, `ECtl` out CW: ID/EX register outputs.
- `StallCnt` out 16: saturating count of stall cycles.

## Operation
- Forward select per operand (shown for A/`Rs`; B/`Rt` identical with `Qb`), first match wins:
  - `Rs == 0` -> 0 (never forwarded, even if a stage targets r0).
  - `E_Wreg && !E_M2reg && E_Wn == Rs` -> `E_Alu`.
  - `M_Wreg && M_Wn == Rs` -> `M_D`.
  - `W_We && W_Wn == Rs` -> `W_D` (register file writes at the same edge, so its read still shows the old value).
  - else `Qa`.
- Load-use hazard `Hz = DValid && E_Wreg && E_M2reg && E_Wn != 0 && ((UseRs && E_Wn == Rs) || (UseRt && E_Wn == Rt))`.
- `Stall = Hz && !Flush` (combinational).
- ID/EX register at posedge:
  - `Flush || Hz || !DValid` -> bubble: `EValid`, `EWreg`, `EM2reg`, `EWmem` = 0, `ECtl` = 0, `EWn` = 0; `EA`/`EB`/`EImm` = 0.
  - else load: `EValid` = 1, `EA`/`EB` = forwarded values, remaining fields copied from the D-side inputs.
- `StallCnt` increments when `Stall` = 1; holds at 0xFFFF.
- No other state; no FSM beyond the pipeline register and counter.

## Timing
- Reset (`Clrn` low, asynchronous, any time including mid-stall): every registered output 0, `StallCnt` = 0; `Stall` still combinational from inputs. First load at the first posedge after `Clrn` rises.
- Forwarding and `Stall` are combinational, same cycle as inputs; data appears on E-side outputs one cycle later (latency 1).
- Load-use costs exactly one stall cycle: the next cycle the load sits in MEM, so `Hz` = 0 and `M_D` is forwarded.
- `Flush` and `Hz` in the same cycle: bubble inserted, `Stall` = 0, counter unchanged.
- `UseRs` = 0 suppresses hazard detection on `Rs` only; forwarding mux still operates.

## Test plan
- Reset: drive `DValid` = 1 with a valid instruction, pulse `Clrn` low mid-cycle -> all E-side outputs and `StallCnt` read 0 immediately, without waiting for a clock edge.
- EX forward: `Rs` = 3, `E_Wreg` = 1, `E_Wn` = 3, `E_Alu` = 0x0000_1234, `Qa` = 0x5 -> after the edge, `EA` = 0x1234 and `EValid` = 1.
- Priority: `Rt` = 7 targeted by E (0xA), M (0xB) and W (0xC) -> `EB` = 0xA; drop E -> 0xB; drop M -> 0xC; drop W -> `Qb`.
- Load-use: `E_M2reg` = 1, `E_Wn` = 5, `Rt` = 5, `UseRt` = 1 -> `Stall` = 1 for exactly 1 cycle, bubble inserted (`EValid` = 0), `StallCnt` = 1. Next cycle, with `M_Wn` = 5 and `M_D` = 0xDEAD_BEEF -> `EB` = 0xDEADBEEF.
- r0: `Rs` = 0, `E_Wn` = 0, `E_Wreg` = 1, `E_M2reg` = 1 -> `EA` = 0 and `Stall` = 0.
- Flush vs hazard: assert `Flush` together with a load-use match -> `Stall` = 0, bubble inserted, `StallCnt` unchanged. Force 70000 stall cycles -> `StallCnt` = 0xFFFF.
